// File: rtl/lfa_share_arb.sv
// Round-robin front end that time-multiplexes one Ladner-Fischer adder between
// NREQ valid/ready requesters, with an operand stage and a backpressured result stage.
module lfa #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum
);
  localparam int LV = $clog2(WIDTH);

  logic [WIDTH-1:0] g0;
  logic [WIDTH-1:0] p0;
  logic [WIDTH-1:0] gf;

  assign g0 = a & b;
  assign p0 = a ^ b;

  genvar gi, bi;
  // Group propagate is only kept for groups not yet reaching bit 0; carry-in is 0,
  // so a group anchored at bit 0 is fully described by its generate.
  for (gi = 0; gi < LV; gi++) begin : lvl
    localparam int S = 1 << gi;
    logic [WIDTH-1:0] gin;
    logic [WIDTH-1:0] gout;
    logic [WIDTH-1:S] pin;
    if (gi == 0) begin : src
      assign gin = g0;
      assign pin = p0[WIDTH-1:1];
    end else begin : src
      assign gin = lvl[gi-1].gout;
      assign pin = lvl[gi-1].pb.pout;
    end
    for (bi = 0; bi < WIDTH; bi++) begin : gb
      if ((bi / S) % 2 == 1) begin : cmb
        assign gout[bi] = gin[bi] | (pin[bi] & gin[(bi / S) * S - 1]);
      end else begin : pas
        assign gout[bi] = gin[bi];
      end
    end
    if (2 * S < WIDTH) begin : pb
      logic [WIDTH-1:2*S] pout;
      for (bi = 2 * S; bi < WIDTH; bi++) begin : pbit
        if ((bi / S) % 2 == 1) begin : cmb
          assign pout[bi] = pin[bi] & pin[(bi / S) * S - 1];
        end else begin : pas
          assign pout[bi] = pin[bi];
        end
      end
    end
  end

  assign gf  = lvl[LV-1].gout;
  assign sum = {gf[WIDTH-1], p0[WIDTH-1:1] ^ gf[WIDTH-2:0], p0[0]};
endmodule

module lfa_share_arb #(
  parameter  int WIDTH = 16,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH:0]        rsp_sum,
  output logic [IDW-1:0]        rsp_id,
  output logic [31:0]           op_count
);
  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW:0]     cand;
  logic             gnt_any;
  logic [NREQ-1:0]  grant;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [IDW-1:0]   s1_id;
  logic             s1_valid;
  logic [WIDTH:0]   lfa_sum;
  logic             s2_free;
  logic             s1_free;
  logic             s1_adv;
  logic             accept;

  genvar gi;
  for (gi = 0; gi < NREQ; gi++) begin : g_slice
    assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
    assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
  end

  // Scan from rr_ptr upward, wrapping modulo NREQ; first valid requester wins.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!gnt_any && req_valid[cand[IDW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[IDW-1:0];
      end
    end
    grant[gnt_idx] = gnt_any;
  end

  assign s2_free   = !rsp_valid || rsp_ready;
  assign s1_free   = !s1_valid || s2_free;
  assign s1_adv    = s1_valid && s2_free;
  assign req_ready = grant & {NREQ{s1_free && rst_n}};
  assign accept    = gnt_any && s1_free && rst_n;

  lfa #(.WIDTH(WIDTH)) u_lfa (
    .a   (s1_a),
    .b   (s1_b),
    .sum (lfa_sum)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_id    <= '0;
      rr_ptr    <= '0;
      op_count  <= '0;
    end else begin
      if (s1_adv) begin
        rsp_valid <= 1'b1;
        rsp_sum   <= lfa_sum;
        rsp_id    <= s1_id;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      if (rsp_valid && rsp_ready) op_count <= op_count + 32'd1;
      if (accept) begin
        s1_valid <= 1'b1;
        s1_a     <= a_arr[gnt_idx];
        s1_b     <= b_arr[gnt_idx];
        s1_id    <= gnt_idx;
        rr_ptr   <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end
endmodule
